// File: rtl/m92_pic_nested.sv
// m92_pic_nested: nested-priority interrupt controller between M92 board sources and the V33.
// Build option: define PIC_ROTATE_EN to enable EOI-driven priority rotation.
module m92_pic_nested #(
  parameter int NUM_IRQ = 8,
  parameter int VEC_W   = 9
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               ce,
  input  logic               cs,
  input  logic               wr,
  input  logic               rd,
  input  logic               a0,
  input  logic [7:0]         din,
  output logic [7:0]         dout,
  output logic               int_req,
  output logic [VEC_W-1:0]   int_vector,
  input  logic               int_ack,
  input  logic [NUM_IRQ-1:0] intp
);
  localparam logic [2:0] ST_UNINIT = 3'd0;
  localparam logic [2:0] ST_IW2    = 3'd1;
  localparam logic [2:0] ST_IW3    = 3'd2;
  localparam logic [2:0] ST_IW4    = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;
  localparam logic [7:0] CH_MASK   = 8'((9'd1 << NUM_IRQ) - 9'd1);

  logic [2:0] state;
  logic       level_mode, need_iw4, single, auto_eoi, read_isr;
  logic [4:0] vec_base;
  logic [7:0] irr, isr, imw, intp_latch, req_in;
  logic [2:0] req_ch, ptr;
  logic       wr_en, iw1_wr, cmd_wr, eoi_wr, sel_wr, ack;
  logic       win_found, top_found, eoi_hit;
  logic [2:0] win_ch, top_ch, eoi_ch;
  logic [7:0] eoi_clr, ack_bit, edge_set, irr_next, isr_next;
  logic       unused_ok;

  // Internal registers are 8 bits wide; channels above NUM_IRQ stay zero.
  assign req_in = 8'(intp) & CH_MASK;

  assign wr_en  = ce && cs && wr;
  assign iw1_wr = wr_en && !a0 && din[4];
  assign cmd_wr = wr_en && !a0 && !din[4] && (state == ST_DONE);
  assign eoi_wr = cmd_wr && !din[3];
  assign sel_wr = cmd_wr && din[3];
  assign ack    = ce && int_req && int_ack;

  assign dout      = a0 ? imw : (read_isr ? isr : irr);
  assign unused_ok = rd;

  // Walk channels from highest to lowest priority; an in-service channel
  // blocks itself and everything below it.
  always_comb begin
    logic [3:0] idx;
    idx       = '0;
    win_found = 1'b0;
    win_ch    = '0;
    top_found = 1'b0;
    top_ch    = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      idx = {1'b0, ptr} + 4'(i);
      if (idx >= 4'(NUM_IRQ)) idx = idx - 4'(NUM_IRQ);
      if (!top_found && isr[idx[2:0]]) begin
        top_found = 1'b1;
        top_ch    = idx[2:0];
      end
      if (!top_found && !win_found && irr[idx[2:0]]) begin
        win_found = 1'b1;
        win_ch    = idx[2:0];
      end
    end
  end

  always_comb begin
    eoi_ch  = top_ch;
    eoi_hit = 1'b0;
    if (din[6]) begin
      eoi_ch  = din[2:0];
      eoi_hit = isr[din[2:0]];
    end else if (din[5]) begin
      eoi_hit = top_found;
    end
  end

  assign eoi_clr  = (eoi_wr && eoi_hit) ? (8'h01 << eoi_ch) : 8'h00;
  assign ack_bit  = 8'h01 << req_ch;
  assign edge_set = req_in & ~intp_latch & ~imw;
  // A fresh edge in the acknowledge cycle re-sets the bit the ack clears.
  assign irr_next = level_mode ? (req_in & ~imw)
                               : ((irr & ~(ack ? ack_bit : 8'h00)) | edge_set);
  assign isr_next = (isr & ~eoi_clr) | ((ack && !auto_eoi) ? ack_bit : 8'h00);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= ST_UNINIT;
      level_mode <= 1'b0;
      need_iw4   <= 1'b0;
      single     <= 1'b0;
      auto_eoi   <= 1'b0;
      read_isr   <= 1'b0;
      vec_base   <= '0;
      irr        <= '0;
      isr        <= '0;
      imw        <= '0;
      intp_latch <= '0;
      req_ch     <= '0;
      int_req    <= 1'b0;
      int_vector <= '0;
    end else if (ce) begin
      intp_latch <= req_in;
      if (iw1_wr) begin
        state      <= ST_IW2;
        level_mode <= din[3];
        single     <= din[1];
        need_iw4   <= din[0];
        auto_eoi   <= 1'b0;
        imw        <= '0;
        irr        <= '0;
        isr        <= '0;
        intp_latch <= '0;
        int_req    <= 1'b0;
      end else begin
        if (wr_en && a0) begin
          case (state)
            ST_IW2: begin
              vec_base <= din[7:3];
              if (!single)       state <= ST_IW3;
              else if (need_iw4) state <= ST_IW4;
              else               state <= ST_DONE;
            end
            ST_IW3:  state <= need_iw4 ? ST_IW4 : ST_DONE;
            ST_IW4: begin
              auto_eoi <= din[1];
              state    <= ST_DONE;
            end
            ST_DONE: imw <= din & CH_MASK;
            default: ;
          endcase
        end
        if (sel_wr && din[1]) read_isr <= din[0];
        if (state == ST_DONE) begin
          irr <= irr_next;
          isr <= isr_next;
          if (ack) begin
            int_req <= 1'b0;
          end else if (!int_req && win_found) begin
            int_req    <= 1'b1;
            req_ch     <= win_ch;
            int_vector <= VEC_W'({vec_base, win_ch, 2'b00});
          end
        end
      end
    end
  end

`ifdef PIC_ROTATE_EN
  // Clearing channel c makes c+1 the highest-priority channel.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptr <= '0;
    end else if (ce) begin
      if (iw1_wr)
        ptr <= '0;
      else if (eoi_wr && eoi_hit && din[7])
        ptr <= (eoi_ch == 3'(NUM_IRQ - 1)) ? 3'd0 : eoi_ch + 3'd1;
    end
  end
`else
  assign ptr = 3'd0;
`endif

endmodule
